proc_controller: RTL and testbench

Control unit of the programmable processor: a Moore state machine that sequences fetch, decode and execute, driving the program counter (clear/increment), the instruction register load and every datapath control line. It sits directly upstream of the PC, which it clears at start-up and increments once per fetched instruction. It consumes the 16-bit instruction held in the IR.

---
 rtl/proc_pkg.sv | 39 +++
 rtl/proc_controller_if.sv | 43 ++++
 rtl/proc_controller.sv | 108 ++++++++++
 tb/tb_proc_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Types and constants shared by the processor control unit and its datapath.
//   state_t   : controller state encoding (also exported on the State output)
//   OP_*      : instruction opcodes, found in IR[15:12]
//   ALU_*     : ALU function select codes
//   opcode()  : extracts the opcode field from an instruction word
// ----------------------------------------------------------------------------
package proc_pkg;

    typedef enum logic [3:0] {
        Init   = 4'd0,
        Fetch  = 4'd1,
        Decode = 4'd2,
        Noop   = 4'd3,
        LoadA  = 4'd4,
        LoadB  = 4'd5,
        Store  = 4'd6,
        Add    = 4'd7,
        Sub    = 4'd8,
        Halt   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    function automatic logic [3:0] opcode(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/proc_controller_if.sv
// ----------------------------------------------------------------------------
// proc_controller_if
// Bundle between the control unit and the datapath.
//   IR                      : instruction word from the instruction register
//   PC_Clr / PC_Up          : program counter clear / increment
//   IR_Ld                   : instruction register load
//   D_Addr / D_Wr           : data memory address / write enable
//   RF_s                    : RF write-data source (1 = data memory, 0 = ALU)
//   RF_W_Addr / RF_W_En     : register file write port
//   RF_Ra_Addr / RF_Rb_Addr : register file read ports
//   ALU_s0                  : ALU function select
//   State                   : controller state, for display and debug
// Modports: master = controller side, slave = datapath side.
// ----------------------------------------------------------------------------
interface proc_controller_if;

    logic [15:0] IR;
    logic        PC_Clr;
    logic        PC_Up;
    logic        IR_Ld;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_En;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  State;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
        output RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
        input  RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State
    );

endinterface

// File: rtl/proc_controller.sv
// ----------------------------------------------------------------------------
// proc_controller
// Moore control unit of the programmable processor. Sequences
// Fetch -> Decode -> Execute and drives the PC, IR load and every datapath
// control line from the current state and the IR contents.
// Ports:
//   Clock : system clock, all state changes on posedge
//   Clr   : synchronous active-high reset, forces Init on the next posedge
//   bus   : proc_controller_if.master (IR in, all control lines out)
// ----------------------------------------------------------------------------
module proc_controller
    import proc_pkg::*;
(
    input  logic               Clock,
    input  logic               Clr,
    proc_controller_if.master  bus
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge Clock) begin
        if (Clr) begin
            r_state <= Init;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.PC_Clr     = 1'b0;
        bus.PC_Up      = 1'b0;
        bus.IR_Ld      = 1'b0;
        bus.D_Addr     = 8'h00;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_Addr  = 4'h0;
        bus.RF_W_En    = 1'b0;
        bus.RF_Ra_Addr = 4'h0;
        bus.RF_Rb_Addr = 4'h0;
        bus.ALU_s0     = ALU_ZERO;

        unique case (r_state)
            Init: begin
                bus.PC_Clr = 1'b1;
                w_next     = Fetch;
            end
            Fetch: begin
                // IR captures the word at the current PC while the PC advances
                bus.IR_Ld = 1'b1;
                bus.PC_Up = 1'b1;
                w_next    = Decode;
            end
            Decode: begin
                case (opcode(bus.IR))
                    OP_STORE: w_next = Store;
                    OP_LOAD:  w_next = LoadA;
                    OP_ADD:   w_next = Add;
                    OP_SUB:   w_next = Sub;
                    OP_HALT:  w_next = Halt;
                    default:  w_next = Noop;  // unassigned opcodes run as NOOP
                endcase
            end
            Noop: begin
                w_next = Fetch;
            end
            LoadA: begin
                // Synchronous data-memory read happens here; write follows in LoadB
                bus.D_Addr    = bus.IR[7:0];
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = bus.IR[11:8];
                w_next        = LoadB;
            end
            LoadB: begin
                bus.D_Addr    = bus.IR[7:0];
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = bus.IR[11:8];
                bus.RF_W_En   = 1'b1;
                w_next        = Fetch;
            end
            Store: begin
                bus.D_Addr     = bus.IR[7:0];
                bus.RF_Ra_Addr = bus.IR[11:8];
                bus.D_Wr       = 1'b1;
                w_next         = Fetch;
            end
            Add, Sub: begin
                bus.RF_Ra_Addr = bus.IR[11:8];
                bus.RF_Rb_Addr = bus.IR[7:4];
                bus.RF_W_Addr  = bus.IR[3:0];
                bus.RF_W_En    = 1'b1;
                bus.ALU_s0     = (r_state == Add) ? ALU_ADD : ALU_SUB;
                w_next         = Fetch;
            end
            Halt: begin
                w_next = Halt;
            end
            default: begin
                // Unused encodings recover through Init
                w_next = Init;
            end
        endcase
    end

    assign bus.State = r_state;

endmodule

// File: tb/tb_proc_controller.sv
// ----------------------------------------------------------------------------
// tb_proc_controller
// Scoreboard bench for proc_controller. The stimulus process expands each
// instruction into its cycle-by-cycle sequence of expected controller outputs
// and queues them; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_proc_controller;
    import proc_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } exp_t;

    logic Clock = 1'b0;
    logic Clr;
    proc_controller_if bus ();

    proc_controller dut (
        .Clock (Clock),
        .Clr   (Clr),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    exp_t exp_q[$];
    string name_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_issued = 0;

    // Output table: what the datapath must see in a given phase with a given IR.
    function automatic exp_t expect_of(input state_t s, input logic [15:0] ir);
        exp_t e;
        e    = '0;
        e.st = s;
        case (s)
            Init:  e.pc_clr = 1'b1;
            Fetch: begin e.ir_ld = 1'b1; e.pc_up = 1'b1; end
            LoadA, LoadB: begin
                e.d_addr = ir[7:0];
                e.rf_s   = 1'b1;
                e.w_addr = ir[11:8];
                e.w_en   = (s == LoadB);
            end
            Store: begin
                e.d_addr = ir[7:0];
                e.ra     = ir[11:8];
                e.d_wr   = 1'b1;
            end
            Add, Sub: begin
                e.ra     = ir[11:8];
                e.rb     = ir[7:4];
                e.w_addr = ir[3:0];
                e.w_en   = 1'b1;
                e.alu    = (s == Add) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input state_t s, input string nm);
        exp_q.push_back(expect_of(s, bus.IR));
        name_q.push_back(nm);
        n_issued++;
        @(posedge Clock);
        #1;
    endtask

    // One instruction from Fetch to its last execute cycle. abort_at selects an
    // execute cycle during which Clr is raised (-1 = run to completion).
    task automatic run_instr(input logic [15:0] ir, input int abort_at, input string nm);
        state_t ph[$];
        step(Fetch, {nm, ":fetch"});
        bus.IR = ir;  // IR load happens on the edge leaving Fetch
        step(Decode, {nm, ":decode"});
        case (ir[15:12])
            4'h1:    ph = '{Store};
            4'h2:    ph = '{LoadA, LoadB};
            4'h3:    ph = '{Add};
            4'h4:    ph = '{Sub};
            default: ph = '{Noop};
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            if (i == abort_at) begin
                Clr = 1'b1;
                step(ph[i], {nm, ":abort"});
                Clr = 1'b0;
                step(Init, {nm, ":init_after_abort"});
                return;
            end
            step(ph[i], {nm, ":exec"});
        end
    endtask

    task automatic run_halt(input logic [15:0] ir, input int cycles, input string nm);
        step(Fetch, {nm, ":fetch"});
        bus.IR = ir;
        step(Decode, {nm, ":decode"});
        for (int i = 0; i < cycles; i++) begin
            if (i == cycles - 1) Clr = 1'b1;
            step(Halt, {nm, ":halt"});
        end
        Clr = 1'b0;
        step(Init, {nm, ":init_after_halt"});
    endtask

    exp_t  m_exp;
    exp_t  m_got;
    string m_nm;

    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            m_nm  = name_q.pop_front();
            m_got = '{st: bus.State, pc_clr: bus.PC_Clr, pc_up: bus.PC_Up, ir_ld: bus.IR_Ld,
                      d_addr: bus.D_Addr, d_wr: bus.D_Wr, rf_s: bus.RF_s,
                      w_addr: bus.RF_W_Addr, w_en: bus.RF_W_En, ra: bus.RF_Ra_Addr,
                      rb: bus.RF_Rb_Addr, alu: bus.ALU_s0};
            n_checks++;
            if (m_got === m_exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t: got st=%0d {%h} required st=%0d {%h}", m_nm, $time,
                         m_got.st, m_got, m_exp.st, m_exp);
            end
        end
    end

    initial begin
        logic [31:0] rnd;
        logic [3:0]  op;
        logic [15:0] ir;
        int          abort_at;

        Clr    = 1'b1;
        bus.IR = 16'h0000;
        @(posedge Clock);
        #1;
        // Clr held high across two sampling edges
        step(Init, "reset_hold");
        Clr = 1'b0;
        step(Init, "reset_release");

        run_instr(16'h3123, -1, "add");
        run_instr(16'h2A1F, -1, "load");
        run_instr(16'h1580, -1, "store");
        run_instr(16'h4456, -1, "sub");
        run_instr(16'hF000, -1, "illegal_noop");
        run_instr(16'h2A1F, 0, "load_abort_a");
        run_instr(16'h2C33, 1, "load_abort_b");
        run_halt(16'h5000, 21, "halt");

        for (int n = 0; n < 250; n++) begin
            rnd = $urandom();
            op  = 4'($urandom_range(0, 15));
            ir  = {op, rnd[11:0]};
            if (op == OP_HALT) begin
                run_halt(ir, int'($urandom_range(1, 6)), "rand_halt");
            end else begin
                abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
                run_instr(ir, abort_at, "rand");
            end
        end

        @(negedge Clock);
        #1;
        n_checks++;
        if (exp_q.size() == 0 && n_checks - 1 == n_issued) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d checked, %0d pending; required %0d checked, 0 pending",
                     n_checks - 1, exp_q.size(), n_issued);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
